x4_word_align_8b10b: RTL

Symbol/word aligner that sits directly upstream of the 4-lane 8b10b decoder. It takes raw 40-bit deserialized words with arbitrary bit slip and searches all 40 bit offsets for the 7-bit comma. It acquires and verifies lock, then drives 10-bit-aligned 40-bit words to the decoder. Decoder error flags are fed back so that persistent errors drop lock and restart the search.

---
 rtl/x4_word_align_8b10b_pkg.sv | 36 +++
 rtl/x4_word_align_8b10b_if.sv | 34 +++
 rtl/x4_word_align_8b10b_comma_detect_x40.sv | 39 +++
 rtl/x4_word_align_8b10b.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/x4_word_align_8b10b_pkg.sv
// Shared constants, state encoding and small helpers for the x4 8b10b word aligner.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package x4_align_8b10b_pkg;

    localparam int SYM_W   = 10;
    localparam int LANES   = 4;
    localparam int WORD_W  = SYM_W * LANES;
    localparam int WIN_W   = 2 * WORD_W;
    localparam int OFF_W   = 6;
    localparam int COMMA_W = 7;

    // Lowest window bit that can belong to a candidate starting at position 39.
    localparam int WIN_LO  = WORD_W - COMMA_W + 1;

    localparam logic [COMMA_W-1:0] COMMA_POS = 7'b0011111;
    localparam logic [COMMA_W-1:0] COMMA_NEG = 7'b1100000;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    function automatic logic is_comma7(input logic [COMMA_W-1:0] bits);
        return (bits == COMMA_POS) || (bits == COMMA_NEG);
    endfunction

    // Symbol phase of a bit position (0..39 -> 0..9).
    function automatic logic [3:0] mod10(input logic [OFF_W-1:0] v);
        logic [OFF_W-1:0] r;
        r = v % OFF_W'(10);
        return r[3:0];
    endfunction

endpackage

// File: rtl/x4_word_align_8b10b_if.sv
// Raw-word input, decoder feedback and aligned-word output of the x4 aligner.
// Latency: none (wiring only).
// Backpressure: none; the stream is free-running, one word per clock.
interface x4_word_align_8b10b_if;
    import x4_align_8b10b_pkg::*;

    logic [WORD_W-1:0] din_dat;
    logic [LANES-1:0]  code_err;
    logic [WORD_W-1:0] dout_dat;
    logic [LANES-1:0]  dout_comma;
    logic              dout_lock;
    logic [OFF_W-1:0]  dout_offset;

    // Upstream deserializer / decoder side.
    modport master (
        output din_dat,
        output code_err,
        input  dout_dat,
        input  dout_comma,
        input  dout_lock,
        input  dout_offset
    );

    // Aligner side.
    modport slave (
        input  din_dat,
        input  code_err,
        output dout_dat,
        output dout_comma,
        output dout_lock,
        output dout_offset
    );

endinterface

// File: rtl/x4_word_align_8b10b_comma_detect_x40.sv
// Flags a 7-bit comma at each of the 40 candidate start positions and finds the lowest one.
// Latency: combinational.
// Backpressure: none.
module comma_detect_x40
    import x4_align_8b10b_pkg::*;
(
    // Only bits 79..34 of the 80-bit window can be covered by a candidate
    // that starts at positions 0..39, so the lower bits are not brought in.
    input  logic [WIN_W-1:WIN_LO] win_i,
    output logic [WORD_W-1:0]     hit_o,
    output logic [OFF_W-1:0]      first_o,
    output logic                  any_o
);

    logic [WORD_W-1:0] hit;

    // Position p starts at window bit 79-p; each start bit is tested once.
    always_comb begin
        hit = '0;
        for (int p = 0; p < WORD_W; p++) begin
            hit[p] = is_comma7(win_i[WIN_W-1-p -: COMMA_W]);
        end
    end

    // Priority pick of the earliest-on-the-wire comma (lowest position).
    always_comb begin
        first_o = '0;
        any_o   = 1'b0;
        for (int p = WORD_W - 1; p >= 0; p--) begin
            if (hit[p]) begin
                first_o = OFF_W'(p);
                any_o   = 1'b1;
            end
        end
    end

    assign hit_o = hit;

endmodule

// File: rtl/x4_word_align_8b10b.sv
// Finds the 8b10b comma in a 40-bit raw stream, verifies and holds lock, emits aligned words.
// Latency: 2 cycles din_dat -> dout_dat (previous-word register + output register).
// Backpressure: none; one word in and one word out every clock, code_err only counted when locked.
module x4_word_align_8b10b
    import x4_align_8b10b_pkg::*;
#(
    parameter int LOCK_CNT   = 4,
    parameter int LOSS_CNT   = 4,
    parameter int GOOD_CNT   = 16,
    parameter int WORD_ALIGN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    x4_word_align_8b10b_if.slave    bus
);

    localparam int CNT_W  = $clog2(LOCK_CNT + 1);
    localparam int ERR_W  = $clog2(LOSS_CNT + 1);
    localparam int GOOD_W = $clog2(GOOD_CNT + 1);

    // Counters are compared against the value one below their target before
    // incrementing, so they never need to hold more than the target itself.
    localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCK_CNT - 1);
    localparam logic [ERR_W-1:0]  LOSS_LAST = ERR_W'(LOSS_CNT - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(GOOD_CNT - 1);

    align_state_e      state_q, state_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [GOOD_W-1:0] good_q, good_d;

    logic [WORD_W-1:0] prev_q;
    logic [WORD_W-1:0] dout_dat_q;
    logic [LANES-1:0]  dout_comma_q;
    logic              dout_lock_q;
    logic [OFF_W-1:0]  dout_offset_q;

    logic [WIN_W-1:0]  win;
    logic [WORD_W-1:0] hit;
    logic [OFF_W-1:0]  first_pos;
    logic              any_hit;
    logic [3:0]        off_phase;
    logic [WORD_W-1:0] phase_mask;
    logic              aligned_any;
    logic              mis_any;
    logic              bad_cycle;
    logic [6:0]        shamt;
    logic [WORD_W-1:0] algn;
    logic [LANES-1:0]  algn_comma;

    // Window: previous word is earlier on the wire, so it sits on top.
    assign win = {prev_q, bus.din_dat};

    comma_detect_x40 u_det (
        .win_i   (win[WIN_W-1:WIN_LO]),
        .hit_o   (hit),
        .first_o (first_pos),
        .any_o   (any_hit)
    );

    // Positions sharing the symbol phase of the held offset count as aligned.
    assign off_phase = mod10(off_q);

    // Build the aligned-phase mask for all 40 candidate positions.
    always_comb begin
        phase_mask = '0;
        for (int p = 0; p < WORD_W; p++) begin
            phase_mask[p] = (mod10(OFF_W'(p)) == off_phase);
        end
    end

    assign aligned_any = |(hit & phase_mask);
    assign mis_any     = |(hit & ~phase_mask);
    assign bad_cycle   = mis_any || (|bus.code_err);

    // Offset k selects w[79-k -: 40]; offset 0 passes the previous word through.
    assign shamt = 7'(WORD_W) - {1'b0, off_q};
    assign algn  = WORD_W'(win >> shamt);

    // Lane j of the aligned word carries a comma in its top 7 bits.
    always_comb begin
        algn_comma = '0;
        for (int j = 0; j < LANES; j++) begin
            algn_comma[j] = is_comma7(algn[SYM_W*j + SYM_W - 1 -: COMMA_W]);
        end
    end

    // Lock FSM: acquire offset in SEARCH, confirm in VERIFY, track errors in LOCKED.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        good_d  = good_q;
        unique case (state_q)
            SEARCH: begin
                if (any_hit) begin
                    if (WORD_ALIGN != 0) begin
                        off_d = first_pos;
                    end else begin
                        off_d = {2'b00, mod10(first_pos)};
                    end
                    cnt_d = CNT_W'(1);
                    if (LOCK_CNT == 1) begin
                        state_d = LOCKED;
                        err_d   = '0;
                        good_d  = '0;
                    end else begin
                        state_d = VERIFY;
                    end
                end
            end
            VERIFY: begin
                // A comma at the wrong phase outranks any aligned one.
                if (mis_any) begin
                    state_d = SEARCH;
                    cnt_d   = '0;
                end else if (aligned_any) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LOCK_LAST) begin
                        state_d = LOCKED;
                        err_d   = '0;
                        good_d  = '0;
                    end
                end
            end
            LOCKED: begin
                if (bad_cycle) begin
                    good_d = '0;
                    if (err_q == LOSS_LAST) begin
                        state_d = SEARCH;
                        cnt_d   = '0;
                        err_d   = '0;
                    end else begin
                        err_d = err_q + ERR_W'(1);
                    end
                end else if (good_q == GOOD_LAST) begin
                    // A full run of good cycles forgives one earlier error.
                    good_d = '0;
                    if (err_q != '0) begin
                        err_d = err_q - ERR_W'(1);
                    end
                end else begin
                    good_d = good_q + GOOD_W'(1);
                end
            end
            default: begin
                state_d = SEARCH;
                cnt_d   = '0;
                err_d   = '0;
                good_d  = '0;
            end
        endcase
    end

    // FSM state, held offset and lock counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
            off_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            good_q  <= good_d;
        end
    end

    // Previous-word register and registered outputs built from this cycle's window.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q        <= '0;
            dout_dat_q    <= '0;
            dout_comma_q  <= '0;
            dout_lock_q   <= 1'b0;
            dout_offset_q <= '0;
        end else begin
            prev_q        <= bus.din_dat;
            dout_dat_q    <= algn;
            dout_comma_q  <= algn_comma;
            dout_lock_q   <= (state_d == LOCKED);
            dout_offset_q <= off_q;
        end
    end

    assign bus.dout_dat    = dout_dat_q;
    assign bus.dout_comma  = dout_comma_q;
    assign bus.dout_lock   = dout_lock_q;
    assign bus.dout_offset = dout_offset_q;

endmodule
